// File: rtl/csa_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pkg
//  Description : Shared constants, stage-control record and the block-count
//                helper for the pipelined carry-select adder.
//  Revision    : 1.0  initial release
// ============================================================================
package csa_pkg;

    // Default operand width and bits resolved per pipeline stage
    localparam int unsigned c_default_width = 16;
    localparam int unsigned c_default_blk   = 4;

    // Per-stage control record. The data part of a stage (partial sum and
    // skewed a/b remainder) is WIDTH-dependent, so it lives beside this record
    // in the top as packed vectors of the parameterised width.
    typedef struct packed {
        logic valid;   // stage holds a live result
        logic carry;   // carry out of the block this stage resolved
    } csa_stage_t;

    // Number of pipeline stages; degenerate parameters collapse to one stage
    // so elaboration reaches the parameter check instead of dividing by zero.
    function automatic int unsigned csa_nblk(input int unsigned width,
                                             input int unsigned blk);
        if (blk == 0) begin
            return 1;
        end
        if ((width / blk) == 0) begin
            return 1;
        end
        return width / blk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_pipe_adder_block.sv
`default_nettype none
// ============================================================================
//  Module      : csa_block
//  Description : Combinational BLK-bit carry-select block. Two ripple chains
//                precompute the sum for carry-in 0 and 1; c_sel picks one.
//  Revision    : 1.0  initial release
// ============================================================================
module csa_block
    import csa_pkg::*;
#(
    parameter int unsigned BLK = c_default_blk
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    input  logic           c_sel,
    output logic [BLK-1:0] s_blk,
    output logic           c_out
);

    logic [BLK-1:0] w_prop;
    logic [BLK-1:0] w_gen;
    logic [BLK-1:0] w_s0;
    logic [BLK-1:0] w_s1;
    logic [BLK:0]   w_c0;
    logic [BLK:0]   w_c1;

    assign w_prop = a_blk ^ b_blk;
    assign w_gen  = a_blk & b_blk;

    // Both candidate ripple chains, one assuming carry-in 0, one carry-in 1
    always_comb begin
        w_s0    = '0;
        w_s1    = '0;
        w_c0    = '0;
        w_c1    = '0;
        w_c0[0] = 1'b0;
        w_c1[0] = 1'b1;
        for (int i = 0; i < int'(BLK); i++) begin
            w_s0[i]   = w_prop[i] ^ w_c0[i];
            w_c0[i+1] = w_gen[i] | (w_prop[i] & w_c0[i]);
            w_s1[i]   = w_prop[i] ^ w_c1[i];
            w_c1[i+1] = w_gen[i] | (w_prop[i] & w_c1[i]);
        end
    end

    // Late-arriving block carry-in only drives the final select
    always_comb begin
        s_blk = c_sel ? w_s1 : w_s0;
        c_out = c_sel ? w_c1[BLK] : w_c0[BLK];
    end

endmodule
`default_nettype wire

// File: rtl/csa_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pipe_adder
//  Description : Pipelined carry-select adder, sum = a + b + cin. One stage per
//                BLK-bit block; stage k selects its block sum with the carry
//                registered by stage k-1. Valid/ready on both sides with one
//                global stall. Latency NBLK cycles, one result per cycle.
//                Optional signed-overflow output enabled by CSA_PIPE_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width,
    parameter int unsigned BLK   = c_default_blk
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef CSA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NBLK = csa_nblk(WIDTH, BLK);
    localparam int unsigned BLK_SAFE = (BLK < 1) ? 1 : BLK;

    if ((BLK < 1) || ((WIDTH % BLK_SAFE) != 0)) begin : g_param_err
        $error("csa_pipe_adder: WIDTH (%0d) must be a positive multiple of BLK (%0d)",
               WIDTH, BLK);
    end

    // Stage outputs, indexed by stage; stage k reads entry k-1
    logic [NBLK-1:0][WIDTH-1:0] w_stg_a;
    logic [NBLK-1:0][WIDTH-1:0] w_stg_b;
    logic [NBLK-1:0][WIDTH-1:0] w_stg_sum;
    csa_stage_t [NBLK-1:0]      w_stg_ctrl;

    // Whole pipe moves together; it can move whenever the output slot frees
    logic w_adv;

    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = w_stg_ctrl[NBLK-1].valid;
    assign sum       = w_stg_sum[NBLK-1];
    assign co        = w_stg_ctrl[NBLK-1].carry;

`ifdef CSA_PIPE_OVF_EN
    logic w_last_ovf;
    assign ovf = w_last_ovf;
`endif

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [WIDTH-1:0] w_src_a;
        logic [WIDTH-1:0] w_src_b;
        logic [WIDTH-1:0] w_src_sum;
        csa_stage_t       w_src_ctrl;
        logic [BLK-1:0]   w_s_blk;
        logic             w_c_blk;
        logic [WIDTH-1:0] w_sum_d;
        csa_stage_t       w_ctrl_d;

        if (k == 0) begin : g_head
            assign w_src_a          = a;
            assign w_src_b          = b;
            assign w_src_sum        = '0;
            assign w_src_ctrl.valid = in_valid;
            assign w_src_ctrl.carry = cin;
        end else begin : g_body
            assign w_src_a    = w_stg_a[k-1];
            assign w_src_b    = w_stg_b[k-1];
            assign w_src_sum  = w_stg_sum[k-1];
            assign w_src_ctrl = w_stg_ctrl[k-1];
        end

        csa_block #(
            .BLK   (BLK)
        ) u_blk (
            .a_blk (w_src_a[k*BLK +: BLK]),
            .b_blk (w_src_b[k*BLK +: BLK]),
            .c_sel (w_src_ctrl.carry),
            .s_blk (w_s_blk),
            .c_out (w_c_blk)
        );

        // Merge this block's resolved bits into the forwarded partial sum
        always_comb begin
            w_sum_d                = w_src_sum;
            w_sum_d[k*BLK +: BLK]  = w_s_blk;
            w_ctrl_d.valid         = w_src_ctrl.valid;
            w_ctrl_d.carry         = w_c_blk;
        end

        if (k < NBLK - 1) begin : g_skew
            logic [WIDTH-1:0] w_a_d;
            logic [WIDTH-1:0] w_b_d;
            logic [WIDTH-1:0] r_a_q;
            logic [WIDTH-1:0] r_b_q;
            logic [WIDTH-1:0] r_sum_q;
            csa_stage_t       r_ctrl_q;

            // Operands travel unmodified so later stages see their blocks
            always_comb begin
                w_a_d = w_src_a;
                w_b_d = w_src_b;
            end

            // Inner stage register: data is don't-care when invalid, so it
            // simply follows the stall
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_q    <= '0;
                    r_b_q    <= '0;
                    r_sum_q  <= '0;
                    r_ctrl_q <= '0;
                end else if (w_adv) begin
                    r_a_q    <= w_a_d;
                    r_b_q    <= w_b_d;
                    r_sum_q  <= w_sum_d;
                    r_ctrl_q <= w_ctrl_d;
                end
            end

            assign w_stg_a[k]    = r_a_q;
            assign w_stg_b[k]    = r_b_q;
            assign w_stg_sum[k]  = r_sum_q;
            assign w_stg_ctrl[k] = r_ctrl_q;
        end else begin : g_tail
            logic [WIDTH-1:0] r_sum_q;
            csa_stage_t       r_ctrl_q;
            // Only the top block of the operands is consumed in the last stage
            logic             w_unused_src;

            assign w_unused_src = ^{w_src_a, w_src_b};

`ifdef CSA_PIPE_OVF_EN
            logic w_ovf_d;
            logic r_ovf_q;

            // Same-sign operands producing an opposite-sign sum overflowed
            always_comb begin
                w_ovf_d = (w_src_a[WIDTH-1] == w_src_b[WIDTH-1]) &&
                          (w_sum_d[WIDTH-1] != w_src_a[WIDTH-1]);
            end

            // Overflow flag moves in lockstep with the result register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf_q <= 1'b0;
                end else if (w_adv && w_ctrl_d.valid) begin
                    r_ovf_q <= w_ovf_d;
                end
            end

            assign w_last_ovf = r_ovf_q;
`endif

            // Output register: visible sum/co change only on a valid result
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum_q  <= '0;
                    r_ctrl_q <= '0;
                end else if (w_adv) begin
                    r_ctrl_q.valid <= w_ctrl_d.valid;
                    if (w_ctrl_d.valid) begin
                        r_sum_q        <= w_sum_d;
                        r_ctrl_q.carry <= w_ctrl_d.carry;
                    end
                end
            end

            assign w_stg_a[k]    = '0;
            assign w_stg_b[k]    = '0;
            assign w_stg_sum[k]  = r_sum_q;
            assign w_stg_ctrl[k] = r_ctrl_q;
        end
    end

    // Last-stage skew slots carry nothing
    logic w_unused_tail;
    assign w_unused_tail = ^{w_stg_a[NBLK-1], w_stg_b[NBLK-1]};

endmodule
`default_nettype wire
